// File: rtl/card_shoe.sv
// 52-card shoe: fills the deck in order, runs a Fisher-Yates shuffle from an LFSR, then deals cards.
// Option: CARD_SHOE_AUTO_RESHUFFLE_EN makes a draw on an empty shoe refill it and serve that draw afterwards.
module card_shoe (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_shuffle_req,
   input  logic       i_draw_req,
   output logic [5:0] o_card,
   output logic       o_card_valid,
   output logic       o_busy,
   output logic [5:0] o_cards_left,
   output logic       o_empty
);

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_PICK  = 2'd1,
      ST_SWAP  = 2'd2,
      ST_READY = 2'd3
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [5:0]  DECK_SIZE = 6'd52;
   localparam logic [5:0]  LAST_IDX  = 6'd51;

   state_t      state_q, state_d;
   logic [5:0]  deck_q [0:51];
   logic [5:0]  deck_d [0:51];
   logic [5:0]  idx_q, idx_d;           // k during FILL, i during PICK/SWAP
   logic [5:0]  j_q, j_d;
   logic [3:0]  fill_rank_q, fill_rank_d;
   logic [1:0]  fill_suit_q, fill_suit_d;
   logic [5:0]  ptr_q, ptr_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [5:0]  card_q, card_d;
   logic        card_valid_q, card_valid_d;
   logic        busy_q, busy_d;
   logic [5:0]  cards_left_q, cards_left_d;
   logic        empty_q, empty_d;
   logic        draw_now;
   logic        start_fill;
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
   logic        pending_q, pending_d;
`endif

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
      state_d      = state_q;
      deck_d       = deck_q;
      idx_d        = idx_q;
      j_d          = j_q;
      fill_rank_d  = fill_rank_q;
      fill_suit_d  = fill_suit_q;
      ptr_d        = ptr_q;
      card_d       = card_q;
      card_valid_d = 1'b0;
      cards_left_d = cards_left_q;
      start_fill   = 1'b0;
      lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      draw_now     = i_draw_req;
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
      pending_d    = pending_q;
      draw_now     = i_draw_req | pending_q;
`endif

      case (state_q)
         ST_FILL: begin
            deck_d[idx_q] = {fill_suit_q, fill_rank_q};
            if (fill_rank_q == 4'd13) begin
               fill_rank_d = 4'd1;
               fill_suit_d = fill_suit_q + 2'd1;
            end else begin
               fill_rank_d = fill_rank_q + 4'd1;
            end
            if (idx_q == LAST_IDX) begin
               idx_d   = LAST_IDX;
               state_d = ST_PICK;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         ST_PICK: begin
            // Rejection sampling keeps j uniform over 0..i.
            if (lfsr_q[5:0] <= idx_q) begin
               j_d     = lfsr_q[5:0];
               state_d = ST_SWAP;
            end
         end
         ST_SWAP: begin
            deck_d[idx_q] = deck_q[j_q];
            deck_d[j_q]   = deck_q[idx_q];
            idx_d         = idx_q - 6'd1;
            if (idx_q == 6'd1) begin
               ptr_d        = 6'd0;
               cards_left_d = DECK_SIZE;
               state_d      = ST_READY;
            end else begin
               state_d = ST_PICK;
            end
         end
         default: begin  // ST_READY
            if (i_shuffle_req) begin
               start_fill = 1'b1;
            end else if (draw_now && (cards_left_q != 6'd0)) begin
               card_d       = deck_q[ptr_q];
               card_valid_d = 1'b1;
               ptr_d        = ptr_q + 6'd1;
               cards_left_d = cards_left_q - 6'd1;
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
               pending_d    = 1'b0;
`endif
            end else if (draw_now) begin
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
               pending_d  = 1'b1;
               start_fill = 1'b1;
`endif
            end
         end
      endcase

      if (start_fill) begin
         state_d      = ST_FILL;
         idx_d        = 6'd0;
         fill_rank_d  = 4'd1;
         fill_suit_d  = 2'd0;
         ptr_d        = 6'd0;
         cards_left_d = 6'd0;
      end

      busy_d  = (state_d != ST_READY);
      empty_d = (state_d == ST_READY) && (cards_left_d == 6'd0);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= ST_FILL;
         idx_q        <= 6'd0;
         j_q          <= 6'd0;
         fill_rank_q  <= 4'd1;
         fill_suit_q  <= 2'd0;
         ptr_q        <= 6'd0;
         lfsr_q       <= LFSR_SEED;
         card_q       <= 6'd0;
         card_valid_q <= 1'b0;
         busy_q       <= 1'b1;
         cards_left_q <= 6'd0;
         empty_q      <= 1'b0;
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
         pending_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         j_q          <= j_d;
         fill_rank_q  <= fill_rank_d;
         fill_suit_q  <= fill_suit_d;
         ptr_q        <= ptr_d;
         lfsr_q       <= lfsr_d;
         card_q       <= card_d;
         card_valid_q <= card_valid_d;
         busy_q       <= busy_d;
         cards_left_q <= cards_left_d;
         empty_q      <= empty_d;
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
         pending_q    <= pending_d;
`endif
      end
   end

   // NOTE: the deck array has no reset; FILL rewrites every entry before any card can be dealt.
   always_ff @(posedge i_clk) begin
      deck_q <= deck_d;
   end

   assign o_card       = card_q;
   assign o_card_valid = card_valid_q;
   assign o_busy       = busy_q;
   assign o_cards_left = cards_left_q;
   assign o_empty      = empty_q;

endmodule

// File: tb/tb_card_shoe.sv
// Directed self-checking bench for card_shoe; follows CARD_SHOE_AUTO_RESHUFFLE_EN when defined.
module tb_card_shoe;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b0;
   logic       i_shuffle_req = 1'b0;
   logic       i_draw_req = 1'b0;
   logic [5:0] o_card;
   logic       o_card_valid;
   logic       o_busy;
   logic [5:0] o_cards_left;
   logic       o_empty;

   int vectors = 0;
   int miscompares = 0;

   localparam int MIN_BUSY = 52 + 51 * 2;

   card_shoe dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_shuffle_req(i_shuffle_req),
      .i_draw_req   (i_draw_req),
      .o_card       (o_card),
      .o_card_valid (o_card_valid),
      .o_busy       (o_busy),
      .o_cards_left (o_cards_left),
      .o_empty      (o_empty)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   // Waits (bounded) for o_busy to drop, counting cycles and strobes seen on the way.
   task automatic wait_ready(output int cycles, output int strobes, output bit timeout);
      cycles  = 0;
      strobes = 0;
      timeout = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         @(negedge i_clk);
         cycles++;
         if (o_card_valid) strobes++;
         if (!o_busy) begin
            timeout = 1'b0;
            break;
         end
      end
   endtask

   // One draw pulse; returns the outputs from the cycle before the pulse and the cycle after it.
   task automatic pulse_draw(output logic gap_valid, output logic [5:0] gap_card,
                             output logic v, output logic [5:0] card, output logic [5:0] left);
      @(negedge i_clk);
      gap_valid  = o_card_valid;
      gap_card   = o_card;
      i_draw_req = 1'b1;
      @(negedge i_clk);
      i_draw_req = 1'b0;
      v    = o_card_valid;
      card = o_card;
      left = o_cards_left;
   endtask

   task automatic pulse_shuffle(input logic with_draw);
      @(negedge i_clk);
      i_shuffle_req = 1'b1;
      i_draw_req    = with_draw;
      @(negedge i_clk);
      i_shuffle_req = 1'b0;
      i_draw_req    = 1'b0;
   endtask

   task automatic test_reset();
      int cyc, stb;
      bit to;
      #2 i_reset = 1'b1;
      #1;
      vectors++;
      if ({o_card, o_card_valid, o_busy, o_cards_left, o_empty} !== {6'd0, 1'b0, 1'b1, 6'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_async: card=%0d valid=%b busy=%b left=%0d empty=%b, required 0 0 1 0 0",
                  o_card, o_card_valid, o_busy, o_cards_left, o_empty);
      end
      repeat (3) @(negedge i_clk);
      i_reset = 1'b0;
      @(negedge i_clk);
      vectors++;
      if (o_busy !== 1'b1 || o_cards_left !== 6'd0) begin
         miscompares++;
         $display("FAIL fill_state: busy=%b left=%0d, required 1 0", o_busy, o_cards_left);
      end
      wait_ready(cyc, stb, to);
      cyc++;
      vectors++;
      if (to || cyc < MIN_BUSY) begin
         miscompares++;
         $display("FAIL busy_time: busy %0d cycles (timeout=%b), required >= %0d", cyc, to, MIN_BUSY);
      end
      vectors++;
      if (stb !== 0) begin
         miscompares++;
         $display("FAIL reset_stray: %0d strobes while busy, required 0", stb);
      end
      vectors++;
      if (o_cards_left !== 6'd52 || o_empty !== 1'b0 || o_card_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL ready_entry: left=%0d empty=%b valid=%b, required 52 0 0",
                  o_cards_left, o_empty, o_card_valid);
      end
   endtask

   task automatic test_draw_all();
      bit         seen [0:63];
      logic       gv, v;
      logic [5:0] gc, c, left, last;
      for (int k = 0; k < 64; k++) seen[k] = 1'b0;
      last = 6'd0;
      for (int n = 0; n < 52; n++) begin
         pulse_draw(gv, gc, v, c, left);
         if (n > 0) begin
            vectors++;
            if (gv !== 1'b0 || gc !== last) begin
               miscompares++;
               $display("FAIL draw_hold[%0d]: valid=%b card=%0h, required 0 %0h", n, gv, gc, last);
            end
         end
         vectors++;
         if (v !== 1'b1 || left !== 6'(51 - n)) begin
            miscompares++;
            $display("FAIL draw_strobe[%0d]: valid=%b left=%0d, required 1 %0d", n, v, left, 51 - n);
         end
         vectors++;
         if (c[3:0] < 4'd1 || c[3:0] > 4'd13 || seen[c]) begin
            miscompares++;
            $display("FAIL draw_code[%0d]: card=%0h rank=%0d dup=%b, required rank 1..13 unique",
                     n, c, c[3:0], seen[c]);
         end
         seen[c] = 1'b1;
         last = c;
      end
      @(negedge i_clk);
      vectors++;
      if (o_empty !== 1'b1 || o_card_valid !== 1'b0 || o_card !== last) begin
         miscompares++;
         $display("FAIL empty_after_52: empty=%b valid=%b card=%0h, required 1 0 %0h",
                  o_empty, o_card_valid, o_card, last);
      end
   endtask

   task automatic test_empty_draw();
      logic       gv, v;
      logic [5:0] gc, c, left;
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
      int cyc, stb;
      bit to;
`endif
      pulse_draw(gv, gc, v, c, left);
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
      vectors++;
      if (v !== 1'b0 || o_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL auto_start: valid=%b busy=%b, required 0 1", v, o_busy);
      end
      wait_ready(cyc, stb, to);
      vectors++;
      if (to || stb !== 0 || o_cards_left !== 6'd52) begin
         miscompares++;
         $display("FAIL auto_ready: timeout=%b strobes=%0d left=%0d, required 0 0 52", to, stb, o_cards_left);
      end
      @(negedge i_clk);
      vectors++;
      if (o_card_valid !== 1'b1 || o_cards_left !== 6'd51) begin
         miscompares++;
         $display("FAIL auto_serve: valid=%b left=%0d, required 1 51", o_card_valid, o_cards_left);
      end
      @(negedge i_clk);
      vectors++;
      if (o_card_valid !== 1'b0 || o_cards_left !== 6'd51) begin
         miscompares++;
         $display("FAIL auto_single: valid=%b left=%0d, required 0 51", o_card_valid, o_cards_left);
      end
`else
      vectors++;
      if (v !== 1'b0 || o_empty !== 1'b1 || left !== 6'd0 || o_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL empty_drop: valid=%b empty=%b left=%0d busy=%b, required 0 1 0 0",
                  v, o_empty, left, o_busy);
      end
      repeat (3) @(negedge i_clk);
      vectors++;
      if (o_card_valid !== 1'b0 || o_empty !== 1'b1 || o_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL empty_stays: valid=%b empty=%b busy=%b, required 0 1 0", o_card_valid, o_empty, o_busy);
      end
`endif
   endtask

   task automatic test_busy_draw();
      int cyc, stb;
      bit to;
      logic       gv, v;
      logic [5:0] gc, c, left;
      pulse_shuffle(1'b0);
      vectors++;
      if (o_busy !== 1'b1 || o_cards_left !== 6'd0) begin
         miscompares++;
         $display("FAIL shuffle_start: busy=%b left=%0d, required 1 0", o_busy, o_cards_left);
      end
      repeat (10) @(negedge i_clk);
      pulse_draw(gv, gc, v, c, left);
      vectors++;
      if (v !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_draw: valid=%b, required 0", v);
      end
      wait_ready(cyc, stb, to);
      vectors++;
      if (to || stb !== 0 || o_cards_left !== 6'd52) begin
         miscompares++;
         $display("FAIL busy_draw_ready: timeout=%b strobes=%0d left=%0d, required 0 0 52", to, stb, o_cards_left);
      end
   endtask

   task automatic test_shuffle_draw();
      int cyc, stb;
      bit to;
      logic       gv, v;
      logic [5:0] gc, c, left;
      for (int n = 0; n < 12; n++) pulse_draw(gv, gc, v, c, left);
      vectors++;
      if (v !== 1'b1 || left !== 6'd40) begin
         miscompares++;
         $display("FAIL draw12: valid=%b left=%0d, required 1 40", v, left);
      end
      @(negedge i_clk);
      pulse_shuffle(1'b1);
      vectors++;
      if (o_card_valid !== 1'b0 || o_busy !== 1'b1 || o_cards_left !== 6'd0) begin
         miscompares++;
         $display("FAIL shuffle_wins: valid=%b busy=%b left=%0d, required 0 1 0",
                  o_card_valid, o_busy, o_cards_left);
      end
      wait_ready(cyc, stb, to);
      vectors++;
      if (to || stb !== 0 || o_cards_left !== 6'd52) begin
         miscompares++;
         $display("FAIL shuffle_ready: timeout=%b strobes=%0d left=%0d, required 0 0 52", to, stb, o_cards_left);
      end
   endtask

   task automatic test_reset_mid_swap();
      int cyc, stb;
      bit to, found;
      logic       gv, v;
      logic [5:0] gc, c, left;
      pulse_draw(gv, gc, v, c, left);  // leaves a nonzero card on o_card
      pulse_shuffle(1'b0);
      found = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         @(negedge i_clk);
         if (n > 60 && dut.state_q == 2'd2) begin
            found = 1'b1;
            break;
         end
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL swap_reach: no SWAP state seen, required one within 2000 cycles");
      end
      #1 i_reset = 1'b1;
      #1;
      vectors++;
      if ({o_card, o_card_valid, o_busy, o_cards_left, o_empty} !== {6'd0, 1'b0, 1'b1, 6'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL swap_reset_async: card=%0h valid=%b busy=%b left=%0d empty=%b, required 0 0 1 0 0",
                  o_card, o_card_valid, o_busy, o_cards_left, o_empty);
      end
      @(negedge i_clk);
      i_reset = 1'b0;
      wait_ready(cyc, stb, to);
      vectors++;
      if (to || stb !== 0 || cyc < MIN_BUSY || o_cards_left !== 6'd52) begin
         miscompares++;
         $display("FAIL swap_refill: timeout=%b strobes=%0d cycles=%0d left=%0d, required 0 0 >=%0d 52",
                  to, stb, cyc, MIN_BUSY, o_cards_left);
      end
      pulse_draw(gv, gc, v, c, left);
      vectors++;
      if (v !== 1'b1 || left !== 6'd51 || c[3:0] < 4'd1 || c[3:0] > 4'd13) begin
         miscompares++;
         $display("FAIL post_reset_draw: valid=%b left=%0d card=%0h, required 1 51 rank 1..13", v, left, c);
      end
   endtask

   initial begin
      test_reset();
      test_draw_all();
      test_empty_draw();
      test_busy_draw();
      test_shuffle_draw();
      test_reset_mid_swap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
